// File: rtl/tex_cache_fill_ctrl.sv
// Fill/lookup sequencer for a 4-bank texture cache: tag compare, victim pick,
// burst line fetch from memory and hit/bank response with LRU access pulse.
module tex_cache_fill_ctrl #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [ADDR_W-1:0]                     req_addr,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic                                  rsp_hit,
  output logic [3:0]                            rsp_bank,
  input  logic [3:0]                            lru,
  output logic                                  lru_read_en,
  output logic [3:0]                            lru_bank_hit,
  output logic                                  mem_req,
  output logic [ADDR_W-$clog2(LINE_WORDS)-1:0]  mem_addr,
  input  logic                                  mem_ack,
  input  logic                                  mem_rvalid,
  input  logic [DATA_W-1:0]                     mem_rdata,
  output logic                                  fill_we,
  output logic [3:0]                            fill_bank,
  output logic [$clog2(LINE_WORDS)-1:0]         fill_word,
  output logic [DATA_W-1:0]                     fill_data
);

  localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned LINE_W = ADDR_W - OFF_W;
  localparam int unsigned CNT_W  = OFF_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MREQ,
    FILL,
    RESP
  } state_t;

  state_t              state, state_n;
  logic [LINE_W-1:0]   tag [4];
  logic [LINE_W-1:0]   tag_n [4];
  logic [3:0]          valid, valid_n;
  logic [LINE_W-1:0]   line, line_n;
  logic [3:0]          victim, victim_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                rsp_hit_q, rsp_hit_n;
  logic [3:0]          rsp_bank_q, rsp_bank_n;
  logic                lru_en_q, lru_en_n;
  logic [3:0]          match;
  logic [3:0]          invalid;
  logic [3:0]          first_inv;

  // Word offset bits select a word inside the line and are not part of the tag.
  logic unused_off;
  assign unused_off = &{1'b0, req_addr[OFF_W-1:0]};

  // Tag compare against every bank.
  always_comb begin
    match = '0;
    for (int i = 0; i < 4; i++) begin
      match[i] = valid[i] && (tag[i] == line);
    end
  end

  // Lowest-index invalid bank: isolate the lowest set bit of ~valid.
  assign invalid   = ~valid;
  assign first_inv = invalid & (4'(~invalid) + 4'd1);

  // Next-state and datapath update.
  always_comb begin
    state_n    = state;
    tag_n      = tag;
    valid_n    = valid;
    line_n     = line;
    victim_n   = victim;
    cnt_n      = cnt;
    rsp_hit_n  = rsp_hit_q;
    rsp_bank_n = rsp_bank_q;
    unique case (state)
      IDLE: begin
        if (flush) begin
          valid_n = '0;
        end else if (req_valid) begin
          line_n  = req_addr[ADDR_W-1:OFF_W];
          state_n = LOOKUP;
        end
      end
      LOOKUP: begin
        if (|match) begin
          rsp_bank_n = match;
          rsp_hit_n  = 1'b1;
          state_n    = RESP;
        end else begin
          victim_n = (|invalid) ? first_inv : lru;
          valid_n  = valid & ~victim_n;
          state_n  = MREQ;
        end
      end
      MREQ: begin
        if (mem_ack) begin
          cnt_n   = '0;
          state_n = FILL;
        end
      end
      FILL: begin
        if (mem_rvalid) begin
          cnt_n = cnt + CNT_W'(1);
          if (cnt == CNT_W'(LINE_WORDS - 1)) begin
            for (int i = 0; i < 4; i++) begin
              if (victim[i]) tag_n[i] = line;
            end
            valid_n    = valid | victim;
            rsp_bank_n = victim;
            rsp_hit_n  = 1'b0;
            state_n    = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    lru_en_n = (state != RESP) && (state_n == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      for (int i = 0; i < 4; i++) tag[i] <= '0;
      valid      <= '0;
      line       <= '0;
      victim     <= '0;
      cnt        <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_bank_q <= '0;
      lru_en_q   <= 1'b0;
    end else begin
      state      <= state_n;
      tag        <= tag_n;
      valid      <= valid_n;
      line       <= line_n;
      victim     <= victim_n;
      cnt        <= cnt_n;
      rsp_hit_q  <= rsp_hit_n;
      rsp_bank_q <= rsp_bank_n;
      lru_en_q   <= lru_en_n;
    end
  end

  // Output decode from registered state; fill path passes memory beats through.
  assign req_ready    = (state == IDLE) && !flush;
  assign rsp_valid    = (state == RESP);
  assign rsp_hit      = rsp_hit_q;
  assign rsp_bank     = rsp_bank_q;
  assign lru_read_en  = lru_en_q;
  assign lru_bank_hit = lru_en_q ? rsp_bank_q : 4'b0000;
  assign mem_req      = (state == MREQ);
  assign mem_addr     = line;
  assign fill_we      = (state == FILL) && mem_rvalid;
  assign fill_bank    = fill_we ? victim : 4'b0000;
  assign fill_word    = fill_we ? cnt[OFF_W-1:0] : '0;
  assign fill_data    = fill_we ? mem_rdata : '0;

endmodule
